// File: rtl/qubit_gate_sequencer.sv
// qubit_gate_sequencer: single-qubit Q16.16 state register and gate-instruction FIFO in front of quantum_gate
//   clk, rst_n (async active-low)
//   init_valid/init_alpha/init_beta : load a new state in IDLE or DONE
//   instr_valid/instr_gate/instr_last/instr_ready : instruction FIFO push side
//   gate_type_o/gate_alpha_o/gate_beta_o -> quantum_gate; gate_alpha_i/gate_beta_i <- quantum_gate
//   alpha_q/beta_q : current state; step_valid : state updated last edge
//   busy/done : RUN/DONE; gate_count : saturating gates since init; norm_err : sticky norm fault
//   NORM_CHECK_EN : when defined, enables the normalisation monitor behind norm_err
module qubit_gate_sequencer #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] NORM_TOL   = 32'h0000_0200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_valid,
  input  logic [31:0]      init_alpha,
  input  logic [31:0]      init_beta,
  input  logic             instr_valid,
  input  logic [2:0]       instr_gate,
  input  logic             instr_last,
  output logic             instr_ready,
  output logic [2:0]       gate_type_o,
  output logic [31:0]      gate_alpha_o,
  output logic [31:0]      gate_beta_o,
  input  logic [31:0]      gate_alpha_i,
  input  logic [31:0]      gate_beta_i,
  output logic [31:0]      alpha_q,
  output logic [31:0]      beta_q,
  output logic             step_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] gate_count,
  output logic             norm_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic empty, push, pop, load;
  assign empty        = cnt == '0;
  assign instr_ready  = cnt != (AW+1)'(FIFO_DEPTH);
  assign push         = instr_valid && instr_ready;
  assign load         = init_valid && state != RUN;
  assign gate_alpha_o = alpha_q;
  assign gate_beta_o  = beta_q;
  assign busy         = state == RUN;
  assign done         = state == DONE;
  always_comb begin
    state_nx    = state;
    gate_type_o = 3'b000;
    pop         = 1'b0;
    unique case (state)
      IDLE: state_nx = empty ? IDLE : RUN;
      RUN: begin
        gate_type_o = empty ? 3'b000 : mem[rd_ptr][2:0];
        pop         = !empty;
        state_nx    = (!empty && mem[rd_ptr][3]) ? DONE : RUN;
      end
      DONE: state_nx = init_valid ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {instr_last, instr_gate};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      alpha_q    <= 32'h0001_0000;
      beta_q     <= '0;
      step_valid <= 1'b0;
      gate_count <= '0;
    end else begin
      state      <= state_nx;
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      cnt        <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      step_valid <= pop;
      if (load) begin
        alpha_q    <= init_alpha;
        beta_q     <= init_beta;
        gate_count <= '0;
      end else if (pop) begin
        alpha_q    <= gate_alpha_i;
        beta_q     <= gate_beta_i;
        gate_count <= (gate_count == '1) ? gate_count : gate_count + CNT_W'(1);
      end
    end
  end
`ifdef NORM_CHECK_EN
  logic signed [63:0] a64, b64, sq;
  logic signed [31:0] n, d;
  logic [31:0] ad;
  assign a64 = {{32{alpha_q[31]}}, alpha_q};
  assign b64 = {{32{beta_q[31]}}, beta_q};
  assign sq  = a64 * a64 + b64 * b64;
  assign n   = 32'(sq >>> 16);
  assign d   = n - 32'sh0001_0000;
  assign ad  = d[31] ? 32'(-d) : d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) norm_err <= 1'b0;
    else if (load) norm_err <= 1'b0;
    else if (ad > NORM_TOL) norm_err <= 1'b1;
  end
`else
  assign norm_err = 1'b0;
`endif
endmodule

// File: tb/tb_qubit_gate_sequencer.sv
// tb_qubit_gate_sequencer: directed bench for qubit_gate_sequencer with a small quantum_gate model
module tb_qubit_gate_sequencer;
  logic clk = 1'b0;
  logic rst_n, init_valid, instr_valid, instr_last, instr_ready;
  logic [31:0] init_alpha, init_beta, gate_alpha_o, gate_beta_o, gate_alpha_i, gate_beta_i, alpha_q, beta_q;
  logic [2:0] instr_gate, gate_type_o;
  logic step_valid, busy, done, norm_err;
  logic [15:0] gate_count;
  int n_cmp = 0;
  int n_err = 0;
  logic exp_norm;
  logic [2:0] bp_gate [5];
  always #5 clk = ~clk;
  qubit_gate_sequencer dut (
    .clk(clk), .rst_n(rst_n), .init_valid(init_valid), .init_alpha(init_alpha), .init_beta(init_beta),
    .instr_valid(instr_valid), .instr_gate(instr_gate), .instr_last(instr_last), .instr_ready(instr_ready),
    .gate_type_o(gate_type_o), .gate_alpha_o(gate_alpha_o), .gate_beta_o(gate_beta_o),
    .gate_alpha_i(gate_alpha_i), .gate_beta_i(gate_beta_i), .alpha_q(alpha_q), .beta_q(beta_q),
    .step_valid(step_valid), .busy(busy), .done(done), .gate_count(gate_count), .norm_err(norm_err)
  );
  // Reference gate model: H uses 1/sqrt(2)=0xB504, Y modelled as (a,b)->(-b,a), codes 0/5-7 identity.
  always_comb begin
    logic signed [63:0] a, b;
    a = {{32{gate_alpha_o[31]}}, gate_alpha_o};
    b = {{32{gate_beta_o[31]}}, gate_beta_o};
    gate_alpha_i = gate_alpha_o;
    gate_beta_i  = gate_beta_o;
    case (gate_type_o)
      3'b001: begin gate_alpha_i = 32'(((a + b) * 46340) >>> 16); gate_beta_i = 32'(((a - b) * 46340) >>> 16); end
      3'b010: begin gate_alpha_i = gate_beta_o; gate_beta_i = gate_alpha_o; end
      3'b011: gate_beta_i = 32'(-b);
      3'b100: begin gate_alpha_i = 32'(-b); gate_beta_i = gate_alpha_o; end
      default: ;
    endcase
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_init(input logic [31:0] a, input logic [31:0] b);
    init_valid = 1'b1; init_alpha = a; init_beta = b;
    tick();
    init_valid = 1'b0;
  endtask
  initial begin
    bp_gate[0] = 3'b010; bp_gate[1] = 3'b001; bp_gate[2] = 3'b100; bp_gate[3] = 3'b101; bp_gate[4] = 3'b011;
    rst_n = 1'b0; init_valid = 1'b0; init_alpha = '0; init_beta = '0;
    instr_valid = 1'b0; instr_gate = '0; instr_last = 1'b0;
    tick(); tick();
    chk("rst_alpha", alpha_q, 32'h0001_0000);
    chk("rst_beta", beta_q, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", gate_count, 0);
    chk("rst_gtype", gate_type_o, 0);
    chk("rst_step", step_valid, 0);
    rst_n = 1'b1;
    tick();
    // Hadamard
    do_init(32'h0001_0000, 0);
    instr_valid = 1'b1; instr_gate = 3'b001; instr_last = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("h_idle_busy", busy, 0);
    tick();
    chk("h_run_busy", busy, 1);
    chk("h_gtype", gate_type_o, 3'b001);
    chk("h_step_pre", step_valid, 0);
    tick();
    chk("h_step", step_valid, 1);
    chk("h_alpha", alpha_q, 32'h0000_B504);
    chk("h_beta", beta_q, 32'h0000_B504);
    chk("h_count", gate_count, 1);
    chk("h_done", done, 1);
    chk("h_busy", busy, 0);
    tick();
    chk("h_step_post", step_valid, 0);
    chk("h_done_hold", done, 1);
    // X then Z, queued while DONE
    instr_valid = 1'b1; instr_gate = 3'b010; instr_last = 1'b0;
    tick();
    instr_gate = 3'b011; instr_last = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("xz_done_hold", done, 1);
    do_init(32'h0001_0000, 0);
    chk("xz_init_count", gate_count, 0);
    chk("xz_init_done", done, 0);
    chk("xz_init_alpha", alpha_q, 32'h0001_0000);
    tick(); tick();
    chk("x_step", step_valid, 1);
    chk("x_alpha", alpha_q, 0);
    chk("x_beta", beta_q, 32'h0001_0000);
    chk("x_count", gate_count, 1);
    chk("x_gtype_next", gate_type_o, 3'b011);
    tick();
    chk("z_alpha", alpha_q, 0);
    chk("z_beta", beta_q, 32'hFFFF_0000);
    chk("z_count", gate_count, 2);
    chk("z_done", done, 1);
    // Back-pressure: 5 offers while DONE, only 4 stored
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr_gate = bp_gate[i]; instr_last = (i == 3);
      chk($sformatf("bp_ready_%0d", i), instr_ready, (i < 4) ? 1 : 0);
      tick();
    end
    instr_valid = 1'b0;
    chk("bp_full", instr_ready, 0);
    chk("bp_done_hold", done, 1);
    do_init(32'h0001_0000, 0);
    tick();
    chk("bp_g0_type", gate_type_o, 3'b010);
    tick();
    chk("bp_g0_step", step_valid, 1);
    chk("bp_g0_alpha", alpha_q, 0);
    chk("bp_g0_beta", beta_q, 32'h0001_0000);
    chk("bp_g1_type", gate_type_o, 3'b001);
    chk("bp_ready_after_pop", instr_ready, 1);
    tick();
    chk("bp_g1_alpha", alpha_q, 32'h0000_B504);
    chk("bp_g1_beta", beta_q, 32'hFFFF_4AFC);
    chk("bp_g2_type", gate_type_o, 3'b100);
    tick();
    chk("bp_g2_alpha", alpha_q, 32'h0000_B504);
    chk("bp_g2_beta", beta_q, 32'h0000_B504);
    chk("bp_g3_type", gate_type_o, 3'b101);
    tick();
    chk("bp_g3_step", step_valid, 1);
    chk("bp_g3_alpha", alpha_q, 32'h0000_B504);
    chk("bp_g3_count", gate_count, 4);
    chk("bp_g3_done", done, 1);
    do_init(32'h0001_0000, 0);
    tick(); tick(); tick();
    chk("bp_fifth_dropped_busy", busy, 0);
    chk("bp_fifth_dropped_step", step_valid, 0);
    chk("bp_fifth_dropped_count", gate_count, 0);
    // Reset during the second of three gates
    instr_valid = 1'b1; instr_gate = 3'b010; instr_last = 1'b0;
    tick(); tick();
    instr_last = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("mr_step1", step_valid, 1);
    chk("mr_alpha1", alpha_q, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_alpha", alpha_q, 32'h0001_0000);
    chk("mr_beta", beta_q, 0);
    chk("mr_step", step_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_count", gate_count, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("mr_post_step", step_valid, 0);
    chk("mr_post_busy", busy, 0);
    chk("mr_post_ready", instr_ready, 1);
    chk("mr_post_alpha", alpha_q, 32'h0001_0000);
    // Normalisation monitor
`ifdef NORM_CHECK_EN
    exp_norm = 1'b1;
`else
    exp_norm = 1'b0;
`endif
    do_init(32'h0001_0000, 32'h0001_0000);
    tick();
    chk("norm_bad", norm_err, exp_norm);
    tick();
    chk("norm_sticky", norm_err, exp_norm);
    do_init(32'h0000_B504, 32'h0000_B504);
    chk("norm_clear", norm_err, 0);
    tick(); tick();
    chk("norm_ok", norm_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/qubit_gate_sequencer.md
Name: qubit_gate_sequencer

Overview:
- Single-qubit state controller placed directly upstream of the combinational `quantum_gate` datapath.
- Holds the current Q16.16 amplitude pair (alpha, beta) in registers and buffers incoming gate instructions in a small FIFO.
- Applies one instruction per cycle: presents the state and gate code to `quantum_gate`, then registers its result back.
- Reports per-step completion, a gate count and program done.

Parameters:
- FIFO_DEPTH, 4, instruction FIFO entries (power of 2, >= 2).
- CNT_W, 16, width of `gate_count`.
- NORM_TOL, 32'h0000_0200, allowed |norm - 1.0| in Q16.16 (used only with NORM_CHECK_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_valid  in  1  load new state (accepted in IDLE/DONE only).
- init_alpha  in  32  signed Q16.16 alpha to load.
- init_beta  in  32  signed Q16.16 beta to load.
- instr_valid  in  1  gate instruction offered.
- instr_gate  in  3  gate code (000 idle, 001 H, 010 X, 011 Z, 100 Y).
- instr_last  in  1  marks the final instruction of a program.
- instr_ready  out  1  FIFO can accept; equals !full.
- gate_type_o  out  3  to `quantum_gate` `gate_type`.
- gate_alpha_o  out  32  to `quantum_gate` `alpha_in`; always equals `alpha_q`.
- gate_beta_o  out  32  to `quantum_gate` `beta_in`; always equals `beta_q`.
- gate_alpha_i  in  32  from `quantum_gate` `alpha_out`.
- gate_beta_i  in  32  from `quantum_gate` `beta_out`.
- alpha_q  out  32  registered current alpha.
- beta_q  out  32  registered current beta.
- step_valid  out  1  one-cycle pulse; `alpha_q`/`beta_q` were updated this edge.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- gate_count  out  CNT_W  gates applied since last init; saturates at all-ones.
- norm_err  out  1  sticky normalisation error.

Behaviour:
- Reset values (async, rst_n=0):
  - alpha_q=32'h0001_0000, beta_q=0.
  - FIFO empty; state IDLE.
  - step_valid, busy, done, norm_err = 0; gate_count=0.
  - gate_type_o=000.
- FIFO:
  - Push on instr_valid && instr_ready, storing {instr_last, instr_gate}.
  - Head is read combinationally; pop is as defined per state.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - instr_valid while full: ignored, nothing stored.
  - Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE:
    - gate_type_o=000.
    - init_valid: load alpha_q/beta_q, clear gate_count and norm_err.
    - FIFO non-empty -> RUN. No pop this cycle.
  - RUN:
    - If FIFO non-empty: gate_type_o = head gate; pop at the edge.
    - At that same edge: alpha_q<=gate_alpha_i, beta_q<=gate_beta_i; step_valid=1 next cycle; gate_count+1 (saturating).
    - If the popped entry had last=1 -> DONE.
    - If FIFO empty: gate_type_o=000, state held, no step_valid, stay RUN.
    - init_valid ignored.
  - DONE:
    - done=1; gate_type_o=000; no pops; pushes still accepted and queued.
    - init_valid: load state, clear gate_count and norm_err -> IDLE.
    - A queued program then starts per IDLE rules.
- Latency:
  - Instruction pushed at edge N is at the FIFO head in cycle N+1.
  - It is applied and popped at edge N+1; alpha_q/beta_q valid and step_valid high in cycle N+2.
- Throughput: 1 gate/cycle while the FIFO is non-empty.
- Gate codes:
  - 101-111 are passed through unchanged; `quantum_gate` treats them as identity.
  - They still count and still pulse step_valid.
- Arithmetic: none local. Saturation and rounding belong to `quantum_gate`; results are registered bit-exact.
- Reset mid-RUN: everything returns to the reset values immediately; queued instructions are lost.

Optional Feature:
- Macro: NORM_CHECK_EN.
- Defined:
  - Each cycle compute n = (alpha_q*alpha_q + beta_q*beta_q) >>> 16, using a 64-bit signed intermediate truncated to Q16.16.
  - If |n - 32'h0001_0000| > NORM_TOL, set norm_err=1 at the next edge.
  - Sticky until init load or reset.
- Undefined: norm_err tied to 0; no multipliers synthesised.

Test Plan:
- Reset check: after reset, alpha_q=0x00010000, beta_q=0, instr_ready=1, done=0, gate_count=0.
- Hadamard step: init (0x00010000, 0), push H with last=1 -> two cycles later alpha_q=beta_q=0x0000B504, step_valid pulse, gate_count=1, done=1.
- X then Z program: X then Z (last on Z) from |0> -> after X (0, 0x00010000); after Z (0, 0xFFFF0000); gate_count=2.
- Back-pressure and ordering:
  - Hold instr_valid while in DONE -> instr_ready drops after 4 pushes; the 5th is not stored.
  - init_valid -> the 4 queued gates execute on consecutive cycles in order.
- Reset mid-run: assert rst_n=0 during the 2nd of 3 gates -> reset values, FIFO empty, no step_valid after release.
- NORM_CHECK_EN check:
  - Init (0x00010000, 0x00010000) -> norm_err=1 next cycle.
  - Re-init (0x0000B504, 0x0000B504) -> norm_err=0.
